// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: issues in-order imem reads at the current PC, buffers
// returned words with their fetch addresses, and hands them to ID over valid/ready.
module if_fetch_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            pc_write,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  logic [PW-1:0]    wr_q, wr_d, fill_q, fill_d, rd_q, rd_d, drop_q, drop_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic [PW-1:0] occ, outstanding;
  logic [AW-1:0] wr_idx, fill_idx, rd_idx;
  logic          req_fire, rsp_drop, rsp_fill, deq;

  assign occ         = wr_q - rd_q;
  assign outstanding = wr_q - fill_q;
  assign wr_idx      = wr_q[AW-1:0];
  assign fill_idx    = fill_q[AW-1:0];
  assign rd_idx      = rd_q[AW-1:0];

  // Credits count both live entries and words still owed to a discarded fetch stream,
  // so a late stale response can never land in a slot reused by a new request.
  assign imem_req_valid = rst_n && !flush && (({1'b0, occ} + {1'b0, drop_q}) < DEPTH_W);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pc_write       = req_fire || flush;

  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_fill = imem_rsp_valid && (drop_q == '0) && (outstanding != '0);

  assign id_valid = rst_n && !flush && filled_q[rd_idx];
  assign id_instr = instr_mem[rd_idx];
  assign id_pc    = pc_mem[rd_idx];
  assign deq      = id_valid && id_ready;

  always_comb begin
    wr_d     = wr_q;
    fill_d   = fill_q;
    rd_d     = rd_q;
    drop_d   = drop_q;
    filled_d = filled_q;
    if (flush) begin
      wr_d     = '0;
      fill_d   = '0;
      rd_d     = '0;
      filled_d = '0;
      drop_d   = outstanding - PW'(rsp_fill) + drop_q - PW'(rsp_drop);
    end else begin
      if (req_fire) wr_d = wr_q + 1'b1;
      if (rsp_drop) drop_d = drop_q - 1'b1;
      if (rsp_fill) begin
        fill_d             = fill_q + 1'b1;
        filled_d[fill_idx] = 1'b1;
      end
      if (deq) begin
        rd_d             = rd_q + 1'b1;
        filled_d[rd_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= '0;
      fill_q   <= '0;
      rd_q     <= '0;
      drop_q   <= '0;
      filled_q <= '0;
    end else begin
      wr_q     <= wr_d;
      fill_q   <= fill_d;
      rd_q     <= rd_d;
      drop_q   <= drop_d;
      filled_q <= filled_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pc_mem[wr_idx] <= pc;
    if (rsp_fill && !flush) instr_mem[fill_idx] <= imem_rsp_data;
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (outstanding == '0) && (drop_q == '0)));

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end for the RV32I pipeline. It consumes the current `pc` and issues in-order read requests to instruction memory. Returned instruction words are buffered together with their fetch addresses and handed to the ID stage over a valid/ready handshake. It drives the PC register's write enable and discards all fetched and in-flight instructions when EX redirects the PC.

## Interface
- XLEN, 32, address/PC width
- DEPTH, 4, fetch-queue entries and maximum in-flight requests; power of two, ≥2

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pc  in  XLEN  current PC (fetch address)
- flush  in  1  EX redirect this cycle (branch taken or jump)
- pc_write  out  1  PC register enable
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  imem accepts request
- imem_req_addr  out  XLEN  fetch address, equals `pc`
- imem_rsp_valid  in  1  instruction word returned; in order, never backpressured, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- id_valid  out  1  instruction available to ID
- id_ready  in  1  ID consumes instruction
- id_instr  out  32  instruction word at queue head
- id_pc  out  XLEN  fetch address of `id_instr`

## Operation
- Ring buffer of DEPTH entries, each holding {pc, instr, filled}.
- Three pointers, each log2(DEPTH)+1 bits: `wr` (issue), `fill` (response), `rd` (ID).
  - `occ` = wr − rd, modulo pointer width.
  - `outstanding` = wr − fill, modulo pointer width.
- Issue:
  - `imem_req_valid` = !flush && (occ + drop_cnt < DEPTH).
  - `imem_req_addr` = `pc`.
  - On acceptance (valid && ready), `pc` is written to entry[wr] and `wr` increments.
- `pc_write` = (imem_req_valid && imem_req_ready) || flush. The PC advances on each accepted fetch, and loads the redirect target on flush.
- Response:
  - If `drop_cnt` > 0: the word is discarded and `drop_cnt` decrements.
  - Otherwise: the word is written to entry[fill], `filled` is set, and `fill` increments.
- Dequeue: `id_valid` = !flush && entry[rd].filled. On id_valid && id_ready, `filled` is cleared and `rd` increments.
- Flush:
  - All entries are invalidated and `wr`, `fill`, `rd` are set to 0.
  - `drop_cnt` is loaded with the in-flight requests not yet answered. The load value is `outstanding`, minus 1 if a non-dropped response arrives this cycle, plus the current `drop_cnt`, minus 1 if a dropped response arrives this cycle.
  - No request is issued and no dequeue occurs in the flush cycle.
- Dropping continues across later cycles. New requests may issue while dropping; in-order return guarantees their responses follow the dropped ones.
- `imem_rsp_valid` with `outstanding` = 0 and `drop_cnt` = 0 is a protocol violation. An assertion flags it and the response is ignored.
- Reset:
  - Pointers, `drop_cnt` and all `filled` bits are cleared.
  - While rst_n is low, imem_req_valid = 0 and id_valid = 0. pc_write = 0 unless `flush` is asserted.

## Timing
- Request accepted in cycle t; response earliest in cycle t+1. A response in cycle N produces id_valid in cycle N+1 (registered entry).
- Best-case issue-to-ID latency is 2 cycles. With single-cycle imem and id_ready high, throughput is 1 instruction/cycle once the pipe fills.
- Queue full (occ + drop_cnt = DEPTH): imem_req_valid is low and pc_write is low, so the PC holds. Issue resumes the cycle after a dequeue frees an entry; there is no combinational ready→valid path.
- Same-cycle events:
  - Response, issue and dequeue may all occur in one cycle, including at occ = DEPTH, where dequeue plus response must not lose data.
  - flush overrides issue and dequeue in the same cycle; a response arriving in the flush cycle is discarded.
- Reset asserted mid-operation clears all state immediately. Responses to pre-reset requests are the environment's responsibility.

## Test plan
- Single-cycle imem, id_ready=1, pc stepping 0x0,0x4,0x8…: id_pc/id_instr emerge in order, first id_valid 2 cycles after the first accept, then one per cycle.
- id_ready=0 with DEPTH=4: exactly 4 accepts (pc 0x0–0xC), then imem_req_valid=0 and pc_write=0. One dequeue re-enables exactly one issue the following cycle.
- imem latency 3 with 3 outstanding, flush pulsed while pc=0x100: pc_write=1 in the flush cycle and drop_cnt=3. The 3 returned words never reach ID; the first id_pc after that is the redirect target.
- flush in the same cycle as a response and a pending dequeue: id_valid=0 that cycle, the response is discarded, and the queue is empty next cycle.
- imem_req_ready toggling 1,0,1,0: pc_write mirrors accepts exactly and id_pc has no gaps or duplicates.
- rst_n asserted with 2 entries filled: id_valid=0 and imem_req_valid=0 immediately. After release the first request carries the current `pc`.
